load_window: RTL and testbench
==============================

LOAD_WINDOW -- requirements
Module: load_window

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- KSIZE, 3, kernel edge; legal range 2..5.
- DATA_WIDTH, 8, activation width in bits.
- BRAM_WIDTH, 32, BRAM word width in bits.
- BRAM_ADDR_BIT, 32, byte-address width.
- BRAM_LAT, 1, BRAM read latency in cycles; legal range 1..2.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the block's single clock.
- rst, in, 1, reset, asynchronous, active-low.
- base_addr, in, BRAM_ADDR_BIT, byte address of pixel (0,0) of the channel plane.
- width, in, 12, plane width in pixels.
- height, in, 12, plane height in pixels.
- stride, in, 3, window step (1..KSIZE).
- frame_start, in, 1, pulse to start a plane scan; sampled in IDLE only.
- win_valid, out, 1, window available.
- win_ready, in, 1, consumer accepts the window.
- window, out, KSIZE*KSIZE*DATA_WIDTH, element (i,j) at bits [(i*KSIZE+j)*DATA_WIDTH +: DATA_WIDTH]; i is the row, 0 is the top row.
- frame_done, out, 1, one-cycle pulse after the last window is accepted.
- busy, out, 1, high in every state except IDLE.
- BRAM_clk, BRAM_en, BRAM_rst, out, 1 each; tied to clk, 1 and 0.
- BRAM_din, out, BRAM_WIDTH, tied to 0.
- BRAM_wen, out, BRAM_WIDTH/8, tied to 0.
- BRAM_addr, out, KSIZE*BRAM_ADDR_BIT, one read port per kernel row.
- BRAM_dout, in, KSIZE*BRAM_WIDTH, read data for each port.

Function
REQ-003 Pixel (r,c) SHALL be located at byte address base_addr + r*width + c. The byte lane SHALL be selected by address bits [log2(BRAM_WIDTH/8)-1:0] of the issuing cycle, delayed by BRAM_LAT cycles.
REQ-004 The FSM SHALL have states IDLE, FETCH, DRAIN and HOLD:
- IDLE goes to FETCH on frame_start.
- FETCH issues N column reads and then goes to DRAIN.
- DRAIN waits BRAM_LAT cycles for the last data and then goes to HOLD.
- HOLD asserts win_valid.
REQ-005 In FETCH, all KSIZE ports SHALL issue in the same cycle. The port k address SHALL be row_addr[k] + col + n, for n = 0..N-1.
REQ-006 Returned byte n from port k SHALL be written to element (k, KSIZE-N+n) of the window.
REQ-007 With column reuse off, N SHALL equal KSIZE. Latency from frame_start, or from a HOLD handshake, to win_valid SHALL be KSIZE+BRAM_LAT+1 cycles.
REQ-008 The window SHALL hold stable while win_valid=1 and win_ready=0.
REQ-009 A handshake in HOLD SHALL advance the position as follows:
- col += stride while col+stride+KSIZE <= width.
- Otherwise col=0 and row += stride while row+stride+KSIZE <= height.
- Otherwise the FSM goes to IDLE and frame_done pulses in the next cycle.
REQ-010 Window count per frame SHALL be ((width-KSIZE)/stride+1)*((height-KSIZE)/stride+1), using integer division.
REQ-011 If width<KSIZE or height<KSIZE, the block SHALL return to IDLE one cycle after frame_start. It SHALL pulse frame_done and SHALL issue no window.
REQ-012 base_addr, width, height and stride SHALL be captured at frame_start. Changes during a frame SHALL be ignored.
REQ-013 frame_start outside IDLE SHALL be ignored.
REQ-014 Address arithmetic SHALL be performed at BRAM_ADDR_BIT width and SHALL wrap modulo 2^BRAM_ADDR_BIT.

Reset
REQ-015 While rst=0, all outputs SHALL be driven as follows:
- win_valid=0, frame_done=0, busy=0.
- window=0 and BRAM_addr=0.
- FSM in IDLE and all counters zero.
REQ-016 Reset asserted mid-FETCH or mid-HOLD SHALL abort the frame. Read data that arrives after reset release SHALL be discarded.

Configuration
REQ-017 Column reuse SHALL be controlled by the macro LOAD_WINDOW_REUSE_EN.
- When it is defined and col != 0, the window SHALL shift left by stride columns and N SHALL equal stride. This gives a latency of stride+BRAM_LAT+1.
- When it is defined and col == 0, or when it is undefined, the block SHALL perform a full KSIZE refetch.
- Window contents SHALL be identical in both builds.

Structure
REQ-018 Package load_window_pkg SHALL hold the FSM state enum, the default parameter constants and a lane-select width function.
REQ-019 Row-address generation (row_addr[k], col, row, wrap and end detection) SHALL live in sub-module window_addr_gen.

Verification
REQ-020 The bench SHALL model memory as byte(a)=a[7:0] with BRAM_LAT=1, and SHALL cover these scenarios:
- KSIZE=3, width=5, height=5, stride=1, base=0 -> first window rows {0,1,2},{5,6,7},{10,11,12}; 9 windows; frame_done once.
- Same with stride=2 -> windows at (0,0),(0,2),(2,0),(2,2); the last window is {12,13,14},{17,18,19},{22,23,24}.
- base=0x103 (unaligned lanes) -> the first window row 0 is {0x03,0x04,0x05}; the window straddles a word boundary correctly.
- win_ready low for 10 cycles in HOLD -> window and win_valid are unchanged, and no BRAM address advances.
- rst pulsed during FETCH -> all outputs return to 0 immediately, and the next frame_start produces a correct first window.
- With LOAD_WINDOW_REUSE_EN and stride=1 -> the second window is valid 3 cycles after the handshake (5 without the macro), with contents identical in both builds.

Source files
------------

// File: rtl/load_window_pkg.sv
// Shared types and defaults for the load_window sliding-window fetcher.
package load_window_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int KSIZE_DEF         = 3;
    localparam int DATA_WIDTH_DEF    = 8;
    localparam int BRAM_WIDTH_DEF    = 32;
    localparam int BRAM_ADDR_BIT_DEF = 32;
    localparam int BRAM_LAT_DEF      = 1;

    // Width of the byte-lane select field; at least one bit so it can be stored.
    function automatic int lane_sel_w(input int bram_width);
        int w;
        w = $clog2(bram_width / 8);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Window position tracker: captures frame geometry, walks (row, col) and
// produces the byte address of the current column 0 for every kernel row.
module window_addr_gen
    import load_window_pkg::*;
#(
    parameter int KSIZE         = KSIZE_DEF,
    parameter int BRAM_ADDR_BIT = BRAM_ADDR_BIT_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            advance,
    input  logic [BRAM_ADDR_BIT-1:0]        base_addr,
    input  logic [11:0]                     width,
    input  logic [11:0]                     height,
    input  logic [2:0]                      stride,
    output logic [KSIZE*BRAM_ADDR_BIT-1:0]  row_addr,
    output logic [11:0]                     col,
    output logic [2:0]                      step,
    output logic                            col_step,
    output logic                            row_step,
    output logic                            size_bad
);

    logic [BRAM_ADDR_BIT-1:0] base_q, base_d;
    logic [11:0]              width_q, width_d;
    logic [11:0]              height_q, height_d;
    logic [2:0]               stride_q, stride_d;
    logic [11:0]              col_q, col_d;
    logic [11:0]              row_q, row_d;
    logic [13:0]              col_end, row_end;
    logic [BRAM_ADDR_BIT-1:0] row_base;

    always_comb begin
        col_end  = 14'(col_q) + 14'(stride_q) + 14'(KSIZE);
        row_end  = 14'(row_q) + 14'(stride_q) + 14'(KSIZE);
        col_step = (col_end <= 14'(width_q));
        row_step = (row_end <= 14'(height_q));
        size_bad = (width < 12'(KSIZE)) || (height < 12'(KSIZE));

        // All address math wraps at the bus width.
        row_base = base_q + BRAM_ADDR_BIT'(row_q) * BRAM_ADDR_BIT'(width_q);
        for (int k = 0; k < KSIZE; k++) begin
            row_addr[k*BRAM_ADDR_BIT +: BRAM_ADDR_BIT] =
                row_base + BRAM_ADDR_BIT'(k) * BRAM_ADDR_BIT'(width_q);
        end
    end

    always_comb begin
        base_d   = base_q;
        width_d  = width_q;
        height_d = height_q;
        stride_d = stride_q;
        col_d    = col_q;
        row_d    = row_q;
        if (start) begin
            base_d   = base_addr;
            width_d  = width;
            height_d = height;
            stride_d = (stride == 3'd0) ? 3'd1 : stride;
            col_d    = '0;
            row_d    = '0;
        end else if (advance) begin
            if (col_step) begin
                col_d = col_q + 12'(stride_q);
            end else if (row_step) begin
                col_d = '0;
                row_d = row_q + 12'(stride_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q   <= '0;
            width_q  <= '0;
            height_q <= '0;
            stride_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            base_q   <= base_d;
            width_q  <= width_d;
            height_q <= height_d;
            stride_q <= stride_d;
            col_q    <= col_d;
            row_q    <= row_d;
        end
    end

    assign col  = col_q;
    assign step = stride_q;

endmodule

// File: rtl/load_window.sv
// KSIZE x KSIZE window fetcher over a byte-addressed BRAM plane, one read port
// per kernel row. Optional column reuse is enabled by macro LOAD_WINDOW_REUSE_EN.
module load_window
    import load_window_pkg::*;
#(
    parameter int KSIZE         = KSIZE_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int BRAM_WIDTH    = BRAM_WIDTH_DEF,
    parameter int BRAM_ADDR_BIT = BRAM_ADDR_BIT_DEF,
    parameter int BRAM_LAT      = BRAM_LAT_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [BRAM_ADDR_BIT-1:0]          base_addr,
    input  logic [11:0]                       width,
    input  logic [11:0]                       height,
    input  logic [2:0]                        stride,
    input  logic                              frame_start,
    output logic                              win_valid,
    input  logic                              win_ready,
    output logic [KSIZE*KSIZE*DATA_WIDTH-1:0] window,
    output logic                              frame_done,
    output logic                              busy,
    output logic                              BRAM_clk,
    output logic                              BRAM_en,
    output logic                              BRAM_rst,
    output logic [BRAM_WIDTH-1:0]             BRAM_din,
    output logic [BRAM_WIDTH/8-1:0]           BRAM_wen,
    output logic [KSIZE*BRAM_ADDR_BIT-1:0]    BRAM_addr,
    input  logic [KSIZE*BRAM_WIDTH-1:0]       BRAM_dout
);

    localparam int LSW = lane_sel_w(BRAM_WIDTH);
    localparam int AW  = BRAM_ADDR_BIT;
    localparam int WW  = KSIZE*KSIZE*DATA_WIDTH;

    state_t                 state_q, state_d;
    logic [2:0]             n_q, n_d;
    logic [2:0]             nfetch_q, nfetch_d;
    logic [1:0]             drain_q, drain_d;
    logic                   done_q, done_d;
    logic [WW-1:0]          win_q, win_d;
    logic [BRAM_LAT-1:0]    pv_q, pv_d;
    logic [2:0]             pcol_q [BRAM_LAT];
    logic [2:0]             pcol_d [BRAM_LAT];
    logic [KSIZE*LSW-1:0]   plane_q [BRAM_LAT];
    logic [KSIZE*LSW-1:0]   plane_d [BRAM_LAT];

    logic                   gen_start, gen_adv;
    logic [KSIZE*AW-1:0]    row_addr;
    logic [11:0]            col;
    logic [2:0]             step;
    logic                   col_step, row_step, size_bad, reuse;
    logic [2:0]             colofs;
    logic [KSIZE*AW-1:0]    issue_addr;
    logic [LSW-1:0]         lane;

    window_addr_gen #(
        .KSIZE        (KSIZE),
        .BRAM_ADDR_BIT(BRAM_ADDR_BIT)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .start    (gen_start),
        .advance  (gen_adv),
        .base_addr(base_addr),
        .width    (width),
        .height   (height),
        .stride   (stride),
        .row_addr (row_addr),
        .col      (col),
        .step     (step),
        .col_step (col_step),
        .row_step (row_step),
        .size_bad (size_bad)
    );

`ifdef LOAD_WINDOW_REUSE_EN
    // Reuse only when staying on the same row band (next col != 0).
    assign reuse = col_step;
`else
    assign reuse = 1'b0;
`endif

    // Fetch only the rightmost nfetch columns; earlier ones are already in place.
    always_comb begin
        colofs = 3'(KSIZE) - nfetch_q + n_q;
        for (int k = 0; k < KSIZE; k++) begin
            issue_addr[k*AW +: AW] = row_addr[k*AW +: AW] + AW'(col) + AW'(colofs);
        end
        BRAM_addr = (state_q == FETCH) ? issue_addr : '0;
    end

    always_comb begin
        pv_d[0]    = (state_q == FETCH);
        pcol_d[0]  = colofs;
        plane_d[0] = '0;
        for (int k = 0; k < KSIZE; k++) begin
            plane_d[0][k*LSW +: LSW] = issue_addr[k*AW +: LSW];
        end
        for (int s = 1; s < BRAM_LAT; s++) begin
            pv_d[s]    = pv_q[s-1];
            pcol_d[s]  = pcol_q[s-1];
            plane_d[s] = plane_q[s-1];
        end
    end

    always_comb begin
        win_d = win_q;
        lane  = '0;
        if (state_q == HOLD && win_ready && reuse) begin
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE; j++) begin
                    if (j + int'(step) < KSIZE) begin
                        win_d[(i*KSIZE+j)*DATA_WIDTH +: DATA_WIDTH] =
                            win_q[(i*KSIZE+j+int'(step))*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
        if (pv_q[BRAM_LAT-1]) begin
            for (int k = 0; k < KSIZE; k++) begin
                lane = (BRAM_WIDTH > 8) ? plane_q[BRAM_LAT-1][k*LSW +: LSW] : '0;
                win_d[(k*KSIZE + int'(pcol_q[BRAM_LAT-1]))*DATA_WIDTH +: DATA_WIDTH] =
                    BRAM_dout[k*BRAM_WIDTH + int'(lane)*8 +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        nfetch_d  = nfetch_q;
        drain_d   = drain_q;
        done_d    = 1'b0;
        gen_start = 1'b0;
        gen_adv   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    gen_start = 1'b1;
                    if (size_bad) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = FETCH;
                        n_d      = '0;
                        nfetch_d = 3'(KSIZE);
                    end
                end
            end
            FETCH: begin
                if (n_q == nfetch_q - 3'd1) begin
                    state_d = DRAIN;
                    n_d     = '0;
                    drain_d = '0;
                end else begin
                    n_d = n_q + 3'd1;
                end
            end
            DRAIN: begin
                if (drain_q == 2'(BRAM_LAT-1)) begin
                    state_d = HOLD;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            HOLD: begin
                if (win_ready) begin
                    gen_adv = 1'b1;
                    if (col_step || row_step) begin
                        state_d  = FETCH;
                        n_d      = '0;
                        nfetch_d = reuse ? step : 3'(KSIZE);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            nfetch_q <= '0;
            drain_q  <= '0;
            done_q   <= 1'b0;
            win_q    <= '0;
            pv_q     <= '0;
            for (int s = 0; s < BRAM_LAT; s++) begin
                pcol_q[s]  <= '0;
                plane_q[s] <= '0;
            end
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            nfetch_q <= nfetch_d;
            drain_q  <= drain_d;
            done_q   <= done_d;
            win_q    <= win_d;
            pv_q     <= pv_d;
            for (int s = 0; s < BRAM_LAT; s++) begin
                pcol_q[s]  <= pcol_d[s];
                plane_q[s] <= plane_d[s];
            end
        end
    end

    assign win_valid  = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;
    assign window     = win_q;
    assign BRAM_clk   = clk;
    assign BRAM_en    = 1'b1;
    assign BRAM_rst   = 1'b0;
    assign BRAM_din   = '0;
    assign BRAM_wen   = '0;

endmodule

// File: tb/tb_load_window.sv
// Directed bench for load_window: byte(a)=a[7:0] memory with one-cycle read latency.
module tb_load_window;

    localparam int K   = 3;
    localparam int DW  = 8;
    localparam int BW  = 32;
    localparam int AB  = 32;
    localparam int LAT = 1;

`ifdef LOAD_WINDOW_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [AB-1:0]     base_addr = '0;
    logic [11:0]       width = '0;
    logic [11:0]       height = '0;
    logic [2:0]        stride = '0;
    logic              frame_start = 1'b0;
    logic              win_valid;
    logic              win_ready = 1'b0;
    logic [K*K*DW-1:0] window;
    logic              frame_done;
    logic              busy;
    logic              BRAM_clk, BRAM_en, BRAM_rst;
    logic [BW-1:0]     BRAM_din;
    logic [BW/8-1:0]   BRAM_wen;
    logic [K*AB-1:0]   BRAM_addr;
    logic [K*BW-1:0]   BRAM_dout = '0;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    load_window #(
        .KSIZE(K), .DATA_WIDTH(DW), .BRAM_WIDTH(BW), .BRAM_ADDR_BIT(AB), .BRAM_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .base_addr(base_addr), .width(width), .height(height),
        .stride(stride), .frame_start(frame_start), .win_valid(win_valid),
        .win_ready(win_ready), .window(window), .frame_done(frame_done), .busy(busy),
        .BRAM_clk(BRAM_clk), .BRAM_en(BRAM_en), .BRAM_rst(BRAM_rst), .BRAM_din(BRAM_din),
        .BRAM_wen(BRAM_wen), .BRAM_addr(BRAM_addr), .BRAM_dout(BRAM_dout)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] al;
        al = {a[31:2], 2'b00};
        return {8'(al + 32'd3), 8'(al + 32'd2), 8'(al + 32'd1), 8'(al)};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < K; k++) begin
            BRAM_dout[k*BW +: BW] <= word_at(BRAM_addr[k*AB +: AB]);
        end
    end

    function automatic logic [71:0] exp_win(input logic [31:0] b, input int w, input int r, input int c);
        logic [71:0] e;
        logic [31:0] a;
        e = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                a = b + 32'((r + i) * w + c + j);
                e[(i*K+j)*8 +: 8] = a[7:0];
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_flags"}, 128'({win_valid, busy, frame_done}), 128'(0));
        check({name, "_window"}, 128'(window), 128'(0));
        check({name, "_addr"}, 128'(BRAM_addr), 128'(0));
    endtask

    task automatic run_frame(input logic [31:0] b, input int w, input int h, input int s,
                             output int nwin, output logic [71:0] fw, output logic [71:0] lw);
        int  r, c, lat, exp_lat;
        bit  fin, got;
        nwin = 0; fw = '0; lw = '0; r = 0; c = 0;
        base_addr = b; width = 12'(w); height = 12'(h); stride = 3'(s);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        // Scramble the configuration: the frame must use the captured copy.
        base_addr = ~b; width = 12'd1; height = 12'd1; stride = 3'd2;
        lat = 1;
        fin = 1'b0;
        while (!fin) begin
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                if (win_valid) got = 1'b1;
                else begin
                    @(negedge clk);
                    lat++;
                end
            end
            if (!got) begin
                check("win_valid_timeout", 128'(0), 128'(1));
                fin = 1'b1;
            end else begin
                exp_lat = (REUSE && c != 0) ? s + LAT + 1 : K + LAT + 1;
                check("latency", 128'(lat), 128'(exp_lat));
                check("window", 128'(window), 128'(exp_win(b, w, r, c)));
                if (nwin == 0) fw = window;
                lw = window;
                nwin++;
                win_ready = 1'b1;
                @(negedge clk);
                win_ready = 1'b0;
                lat = 1;
                if (c + s + K <= w) c += s;
                else if (r + s + K <= h) begin
                    c = 0;
                    r += s;
                end else begin
                    check("frame_done_pulse", 128'({frame_done, busy}), 128'(2'b10));
                    @(negedge clk);
                    check("frame_done_clear", 128'({frame_done, busy, win_valid}), 128'(0));
                    fin = 1'b1;
                end
            end
        end
    endtask

    typedef struct {
        logic [31:0] base;
        int          w;
        int          h;
        int          s;
        int          exp_n;
        logic [7:0]  first_tl;
        logic [7:0]  last_br;
    } vec_t;

    vec_t        vecs[6];
    logic [71:0] fws[6];
    logic [71:0] lws[6];

    initial begin
        int          n;
        logic [71:0] fw, lw, w0;
        bit          got;

        vecs[0] = '{32'h0000_0000, 5, 5, 1, 9, 8'h00, 8'h18};
        vecs[1] = '{32'h0000_0000, 5, 5, 2, 4, 8'h00, 8'h18};
        vecs[2] = '{32'h0000_0103, 5, 5, 1, 9, 8'h03, 8'h1B};
        vecs[3] = '{32'h0000_0000, 7, 4, 3, 2, 8'h00, 8'h13};
        vecs[4] = '{32'hFFFF_FFFE, 4, 3, 1, 2, 8'hFE, 8'h09};
        vecs[5] = '{32'h0000_0020, 3, 3, 3, 1, 8'h20, 8'h28};

        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].base, vecs[v].w, vecs[v].h, vecs[v].s, n, fw, lw);
            fws[v] = fw;
            lws[v] = lw;
            check("window_count", 128'(n), 128'(vecs[v].exp_n));
            check("first_top_left", 128'(fw[7:0]), 128'(vecs[v].first_tl));
            check("last_bottom_right", 128'(lw[71:64]), 128'(vecs[v].last_br));
        end

        check("s1_first_window", 128'(fws[0]),
              128'({8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0}));
        check("s2_last_window", 128'(lws[1]),
              128'({8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12}));
        check("unaligned_row0", 128'(fws[2][23:0]), 128'(24'h05_04_03));

        // Plane narrower than the kernel: immediate done, no window.
        base_addr = '0; width = 12'd2; height = 12'd5; stride = 3'd1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("small_done", 128'({frame_done, win_valid}), 128'(2'b10));
        @(negedge clk);
        check("small_idle", 128'({frame_done, busy, win_valid}), 128'(0));

        // Consumer stall in HOLD, with a stray frame_start that must be ignored.
        base_addr = '0; width = 12'd5; height = 12'd5; stride = 3'd1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            if (win_valid) got = 1'b1;
            else @(negedge clk);
        end
        check("stall_reached_hold", 128'(got), 128'(1));
        w0 = window;
        check("stall_first_window", 128'(w0), 128'(exp_win(32'h0, 5, 0, 0)));
        for (int t = 0; t < 10; t++) begin
            frame_start = (t == 3);
            base_addr = 32'h55;
            width = 12'd9;
            @(negedge clk);
            check("stall_valid", 128'(win_valid), 128'(1));
            check("stall_window", 128'(window), 128'(w0));
            check("stall_addr", 128'(BRAM_addr), 128'(0));
        end
        frame_start = 1'b0;

        // Reset in HOLD aborts the frame.
        rst = 1'b0;
        #1;
        check_zero_outputs("rst_hold");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset in the middle of FETCH, then a clean frame.
        base_addr = '0; width = 12'd5; height = 12'd5; stride = 3'd1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        check("fetch_busy", 128'({busy, win_valid}), 128'(2'b10));
        rst = 1'b0;
        #1;
        check_zero_outputs("rst_fetch");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_frame(32'h0, 5, 5, 1, n, fw, lw);
        check("after_rst_count", 128'(n), 128'(9));
        check("after_rst_first", 128'(fw),
              128'({8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0}));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
